// File: rtl/rrarb_wrr_if.sv
// Request/grant bundle between the requesters and the weighted round-robin arbiter.
// The requester side uses the master modport and the arbiter uses the slave modport.
interface rrarb_wrr_if #(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req_i;
  logic [NUM_REQ*WEIGHT_W-1:0] weight_i;
  logic [NUM_REQ-1:0]          gnt_o;
  logic                        gnt_valid_o;
  logic [ID_W-1:0]             gnt_id_o;

  modport master (
    output req_i,
    output weight_i,
    input  gnt_o,
    input  gnt_valid_o,
    input  gnt_id_o
  );

  modport slave (
    input  req_i,
    input  weight_i,
    output gnt_o,
    output gnt_valid_o,
    output gnt_id_o
  );
endinterface

// File: rtl/rrarb_wrr.sv
// Weighted round-robin arbiter. The grant is registered, and a granted requester may keep
// the grant for up to its weight in consecutive cycles while it is still requesting.
module rrarb_wrr #(
  parameter int NUM_REQ  = 4,
  parameter int WEIGHT_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  rrarb_wrr_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_HOLD,
    DEC_ARB
  } dec_e;

  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic                valid_q, valid_d;

  dec_e                dec;
  logic                found;
  logic [ID_W-1:0]     win;
  logic [WEIGHT_W-1:0] win_weight;

  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // A weight of 0 behaves like 1: the winner gets one cycle and no extra credit.
  function automatic logic [WEIGHT_W-1:0] burst_credit(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? '0 : w - WEIGHT_W'(1);
  endfunction

  // The owner sits at offset NUM_REQ, so it is searched last.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    found = 1'b0;
    win   = ptr_q;
    for (int j = 1; j <= NUM_REQ; j++) begin
      if (!found && bus.req_i[rot_idx(ptr_q, j)]) begin
        found = 1'b1;
        win   = rot_idx(ptr_q, j);
      end
    end
  end

  assign win_weight = bus.weight_i[int'(win)*WEIGHT_W +: WEIGHT_W];

  always_comb begin
    if (gnt_q[ptr_q] && bus.req_i[ptr_q] && (cnt_q != '0)) begin
      dec = DEC_HOLD;
    end else if (found) begin
      dec = DEC_ARB;
    end else begin
      dec = DEC_IDLE;
    end
  end

  always_comb begin
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    valid_d = valid_q;
    unique case (dec)
      DEC_HOLD: begin
        cnt_d = cnt_q - WEIGHT_W'(1);
      end
      DEC_ARB: begin
        gnt_d      = '0;
        gnt_d[win] = 1'b1;
        ptr_d      = win;
        id_d       = win;
        valid_d    = 1'b1;
        cnt_d      = burst_credit(win_weight);
      end
      DEC_IDLE: begin
        gnt_d   = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
      default: begin
        gnt_d   = '0;
        id_d    = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Reset points the pointer at the last requester, so the first search begins at requester 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q   <= '0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    bus.gnt_o       = gnt_q;
    bus.gnt_valid_o = valid_q;
    bus.gnt_id_o    = id_q;
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt_q));
  a_gnt_requested : assert property (@(posedge clk) disable iff (!reset_n)
                                     (gnt_d != '0) |-> ((gnt_d & bus.req_i) == gnt_d));
  a_valid_matches : assert property (@(posedge clk) disable iff (!reset_n) valid_q == (|gnt_q));
endmodule

// File: tb/tb_rrarb_wrr.sv
// Self-checking bench for rrarb_wrr: a vector table is driven cycle by cycle, and the expected
// grants are queued and checked one edge later, with hand-written async-reset sequences.
module tb_rrarb_wrr;
  localparam int NUM_REQ  = 4;
  localparam int WEIGHT_W = 4;

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [15:0] weight;
    logic [3:0]  gnt;
    string       name;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    string      name;
  } exp_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  exp_t exp_q[$];

  rrarb_wrr_if #(.NUM_REQ(NUM_REQ), .WEIGHT_W(WEIGHT_W)) bus ();

  rrarb_wrr #(.NUM_REQ(NUM_REQ), .WEIGHT_W(WEIGHT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return 0;
  endfunction

  // Checker: each queued expectation is compared just after the edge that follows its stimulus.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, " gnt"},   32'(bus.gnt_o),       32'(e.gnt));
      check({e.name, " valid"}, 32'(bus.gnt_valid_o), 32'(|e.gnt));
      check({e.name, " id"},    32'(bus.gnt_id_o),    onehot_idx(e.gnt));
    end
  end

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.req_i    = 4'b1011;
    bus.weight_i = 16'h1111;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset gnt",   32'(bus.gnt_o),       32'h0);
      check("reset valid", 32'(bus.gnt_valid_o), 32'h0);
      check("reset id",    32'(bus.gnt_id_o),    32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    if (v.rst) do_reset();
    bus.req_i    = v.req;
    bus.weight_i = v.weight;
    e.gnt  = v.gnt;
    e.name = v.name;
    exp_q.push_back(e);
  endtask

  task automatic add(input bit rst, input logic [3:0] req, input logic [15:0] w,
                     input logic [3:0] gnt, input string name);
    vec_t v;
    v.rst = rst; v.req = req; v.weight = w; v.gnt = gnt; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    bus.req_i    = '0;
    bus.weight_i = '0;

    // Plain round-robin, all weights 1.
    add(1, 4'b1011, 16'h1111, 4'b0001, "rr");
    add(0, 4'b1011, 16'h1111, 4'b0010, "rr"); add(0, 4'b1011, 16'h1111, 4'b1000, "rr");
    add(0, 4'b1011, 16'h1111, 4'b0001, "rr"); add(0, 4'b1011, 16'h1111, 4'b0010, "rr");
    add(0, 4'b1011, 16'h1111, 4'b1000, "rr");
    // Weighted: w0=3 w1=1 w2=5 w3=2, requester 2 idle.
    for (int r = 0; r < 2; r++) begin
      add(r == 0, 4'b1011, 16'h2513, 4'b0001, "wrr");
      add(0, 4'b1011, 16'h2513, 4'b0001, "wrr"); add(0, 4'b1011, 16'h2513, 4'b0001, "wrr");
      add(0, 4'b1011, 16'h2513, 4'b0010, "wrr");
      add(0, 4'b1011, 16'h2513, 4'b1000, "wrr"); add(0, 4'b1011, 16'h2513, 4'b1000, "wrr");
    end
    // Early release: requester 0 drops after 2 of 4 cycles, then gets a fresh burst.
    add(1, 4'b0011, 16'h1114, 4'b0001, "early"); add(0, 4'b0011, 16'h1114, 4'b0001, "early");
    add(0, 4'b0010, 16'h1114, 4'b0010, "early");
    add(0, 4'b0011, 16'h1114, 4'b0001, "early"); add(0, 4'b0011, 16'h1114, 4'b0001, "early");
    add(0, 4'b0011, 16'h1114, 4'b0001, "early"); add(0, 4'b0011, 16'h1114, 4'b0001, "early");
    add(0, 4'b0011, 16'h1114, 4'b0010, "early");
    // Weight 0 sole requester, then idle.
    add(1, 4'b0100, 16'h1011, 4'b0100, "w0"); add(0, 4'b0100, 16'h1011, 4'b0100, "w0");
    add(0, 4'b0100, 16'h1011, 4'b0100, "w0"); add(0, 4'b0100, 16'h1011, 4'b0100, "w0");
    add(0, 4'b0000, 16'h1011, 4'b0000, "idle");
    // Weight change mid-burst does not shorten the running burst.
    add(1, 4'b0011, 16'h1113, 4'b0001, "wchg"); add(0, 4'b0011, 16'h1111, 4'b0001, "wchg");
    add(0, 4'b0011, 16'h1111, 4'b0001, "wchg"); add(0, 4'b0011, 16'h1111, 4'b0010, "wchg");
    add(0, 4'b0011, 16'h1111, 4'b0001, "wchg");

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Async reset mid-burst: requester 1 with weight 5, pulse reset between edges.
    begin
      vec_t v;
      v.rst = 1; v.req = 4'b0010; v.weight = 16'h1151; v.gnt = 4'b0010; v.name = "areset";
      apply(v);
      v.rst = 0;
      apply(v);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("async gnt",   32'(bus.gnt_o),       32'h0);
      check("async valid", 32'(bus.gnt_valid_o), 32'h0);
      check("async id",    32'(bus.gnt_id_o),    32'h0);
      reset_n = 1'b1;
      v.req = 4'b0011; v.gnt = 4'b0001; v.name = "after_areset";
      apply(v);
    end

    repeat (2) @(posedge clk);
    #2;
    check("queue drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rrarb_wrr.md
Name: rrarb_wrr

Overview:
Parametrised weighted round-robin arbiter. It is the successor to the fixed 4-requester rrarb and serves NUM_REQ requesters. Each requester has a programmable weight, and a granted requester may hold the grant for up to that many consecutive cycles (burst) while it keeps requesting. The grant is registered, and the block sits in front of any shared resource (bus, memory port, FIFO write side).

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WEIGHT_W, 4, width of each per-requester weight field
ID_W, $clog2(NUM_REQ), width of granted-index output (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
req_i  input  NUM_REQ  request vector, bit i = requester i
weight_i  input  NUM_REQ*WEIGHT_W  packed weights, requester i at [i*WEIGHT_W +: WEIGHT_W]
gnt_o  output  NUM_REQ  one-hot (or zero) registered grant
gnt_valid_o  output  1  registered, = |gnt_o
gnt_id_o  output  ID_W  registered index of granted requester, 0 when no grant

Behaviour:
- Reset (reset_n low, asynchronous, takes effect without clk):
  - gnt_o=0, gnt_valid_o=0, gnt_id_o=0.
  - Internal last-owner pointer ptr_q=NUM_REQ-1, so the first search starts at requester 0.
  - Burst credit cnt_q=0.
- Latency: decision uses req_i sampled at edge k; the resulting grant is visible after edge k. A request asserted before edge k is granted no earlier than that edge.
- Effective weight: eff_w(i) = weight_i[i], with 0 treated as 1. Maximum burst = 2^WEIGHT_W-1 cycles.
- Per-cycle next-state (owner = ptr_q):
  - HOLD: gnt_o[owner]=1 AND req_i[owner]=1 AND cnt_q!=0 -> keep grant; cnt_q <= cnt_q-1; ptr_q unchanged.
  - ARBITRATE: otherwise, search indices (owner+1) mod N, (owner+2) mod N, ..., owner, in that order. The first index k with req_i[k]=1 wins:
    - gnt_o <= onehot(k)
    - ptr_q <= k
    - cnt_q <= eff_w(k)-1
    - weight of k is sampled only here
  - IDLE: no req_i bit set -> gnt_o <= 0; ptr_q and cnt_q unchanged (cnt_q is irrelevant because gnt_o=0 forces ARBITRATE next).
- Owner dropping req_i mid-burst: the remaining credit is forfeited and the next cycle goes to ARBITRATE. The owner is searched last, so it is re-granted only if no other requester is active.
- Burst exhausted (cnt_q=0) while the owner still requests: ARBITRATE. Another active requester wins if present; otherwise the owner is re-granted with fresh credit.
- Changes to weight_i during a burst do not affect the current burst.
- gnt_o is never multi-hot. gnt_o is never set for a requester whose req_i was 0 at the deciding edge.
- Fairness: with all requesters continuously active, each requester i gets exactly eff_w(i) grant cycles per rotation, in ascending index order after reset.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset hold: reset_n=0, req_i=4'b1011 -> gnt_o=0, gnt_valid_o=0, gnt_id_o=0 on every edge while reset_n is low.
2. Plain round-robin: all weights 1, req_i=4'b1011 held after reset release -> gnt_o sequence 0001, 0010, 1000, 0001, 0010, 1000; gnt_id_o 0, 1, 3, 0, 1, 3.
3. Weighted: weights w0=3, w1=1, w2=5, w3=2, req_i=4'b1011 held -> gnt_o 0001 x3, 0010 x1, 1000 x2, repeating. Requester 2 is never granted.
4. Early release: w0=4, req_i=4'b0011. Drop req_i[0] after requester 0's 2nd grant cycle -> next gnt_o=0010, and requester 0's leftover credit is lost. Re-raise req_i[0] -> requester 0 gets a fresh 4-cycle burst after requester 1's burst.
5. Weight 0 and sole requester: w2=0, req_i=4'b0100 held -> gnt_o=0100 every cycle, re-arbitrated each cycle (cnt_q stays 0). Then req_i=0 -> gnt_o=0, gnt_valid_o=0 next edge.
6. Async reset mid-burst: w1=5, requester 1 in its 2nd grant cycle; pulse reset_n low between edges -> gnt_o=0 immediately, without a clock edge. After release with req_i=4'b0011 -> first grant 0001.
